dw_simd_sequencer: RTL and testbench

//  Sequences SIMD_execution for 3x3 depthwise conv: streams FILTER_SIZE kernel/activation beats per window

---
 rtl/dw_pkg.sv | 22 ++
 rtl/dw_seq_addr_gen.sv | 64 ++++++
 rtl/dw_simd_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_dw_simd_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dw_pkg.sv
// ---------------------------------------------------------------------------
// dw_pkg
// Shared defaults and FSM encoding for the depthwise-conv SIMD sequencer.
// No ports. Imported by dw_seq_addr_gen and dw_simd_sequencer.
// ---------------------------------------------------------------------------
package dw_pkg;

    localparam int DW_NUM_PE         = 16;
    localparam int DW_DATA_WIDTH     = 8;
    localparam int DW_OUT_DATA_WIDTH = 32;
    localparam int DW_FILTER_SIZE    = 9;
    localparam int DW_ADDR_WIDTH     = 18;
    localparam int DW_WIN_WIDTH      = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/dw_seq_addr_gen.sv
// ---------------------------------------------------------------------------
// dw_seq_addr_gen
// Window/beat counters for the sequencer. mem_addr = win*FILTER_SIZE + beat,
// kept as a running window base plus beat offset so no multiplier is needed.
// Ports:
//   clk, reset      clock, sync active-high reset
//   clear           restart counters at window 0 / beat 0 (start accepted)
//   adv             a beat address was issued this cycle; step to the next
//   last_win        index of the final window of the run
//   win             current window index
//   mem_addr        buffer address of the current beat
//   first_beat      current beat is beat 0
//   last_beat       current beat is beat FILTER_SIZE-1
//   final_beat      last beat of the final window
// ---------------------------------------------------------------------------
module dw_seq_addr_gen
    import dw_pkg::*;
#(
    parameter int ADDR_WIDTH  = DW_ADDR_WIDTH,
    parameter int WIN_WIDTH   = DW_WIN_WIDTH,
    parameter int FILTER_SIZE = DW_FILTER_SIZE
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  adv,
    input  logic [WIN_WIDTH-1:0]  last_win,
    output logic [WIN_WIDTH-1:0]  win,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  first_beat,
    output logic                  last_beat,
    output logic                  final_beat
);

    localparam int BEAT_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;

    logic [BEAT_W-1:0]     beat;
    logic [ADDR_WIDTH-1:0] base;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            win  <= '0;
            beat <= '0;
            base <= '0;
        end else if (adv) begin
            if (last_beat) begin
                beat <= '0;
                // The counter never wraps past the final window.
                if (!final_beat) begin
                    win  <= win + WIN_WIDTH'(1);
                    base <= base + ADDR_WIDTH'(FILTER_SIZE);
                end
            end else begin
                beat <= beat + BEAT_W'(1);
            end
        end
    end

    assign first_beat = (beat == '0);
    assign last_beat  = (beat == BEAT_W'(FILTER_SIZE - 1));
    assign final_beat = last_beat && (win == last_win);
    assign mem_addr   = base + ADDR_WIDTH'(beat);

endmodule

// File: rtl/dw_simd_sequencer.sv
// ---------------------------------------------------------------------------
// dw_simd_sequencer
// Streams FILTER_SIZE kernel/activation beats per window from two sync-read
// buffers into the SIMD array, then captures the window Result into an
// output register with a valid/ready handshake.
//
// Pipeline: stage A issues mem_rd/mem_addr; stage D (next cycle) presents the
// returned buffer data as Kernel/Input_Act with first_data on beat 0. Cycles
// with no beat in D drive zeros so the SIMD accumulator holds its value.
//
// Ports:
//   clk, reset          clock, sync active-high reset
//   start, num_windows  begin a run of num_windows windows (ignored when busy)
//   busy, done          run in progress / 1-cycle completion pulse
//   mem_addr, mem_rd    shared read address/strobe for kernel and act buffers
//   k_rdata, a_rdata    buffer read data (one cycle after mem_rd)
//   first_data, Kernel, Input_Act   beat stream to the SIMD array
//   Result              SIMD window sum, valid one cycle after the last beat
//   out_valid, out_ready, out_data, out_win   captured result handshake
//   perf_cycles, perf_stalls (only with DW_SEQ_PERF_CNT_EN defined)
//                       busy-cycle and boundary-stall counters, saturating
// ---------------------------------------------------------------------------
module dw_simd_sequencer
    import dw_pkg::*;
#(
    parameter int NUM_PE         = DW_NUM_PE,
    parameter int DATA_WIDTH     = DW_DATA_WIDTH,
    parameter int OUT_DATA_WIDTH = DW_OUT_DATA_WIDTH,
    parameter int FILTER_SIZE    = DW_FILTER_SIZE,
    parameter int ADDR_WIDTH     = DW_ADDR_WIDTH,
    parameter int WIN_WIDTH      = DW_WIN_WIDTH
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [WIN_WIDTH-1:0]             num_windows,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic                             mem_rd,
    input  logic [NUM_PE*DATA_WIDTH-1:0]     k_rdata,
    input  logic [NUM_PE*DATA_WIDTH-1:0]     a_rdata,
    output logic                             first_data,
    output logic [NUM_PE*DATA_WIDTH-1:0]     Kernel,
    output logic [NUM_PE*DATA_WIDTH-1:0]     Input_Act,
    input  logic [NUM_PE*OUT_DATA_WIDTH-1:0] Result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_PE*OUT_DATA_WIDTH-1:0] out_data,
    output logic [WIN_WIDTH-1:0]             out_win
`ifdef DW_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                      perf_cycles,
    output logic [31:0]                      perf_stalls
`endif
);

    seq_state_e           state;
    logic [WIN_WIDTH-1:0] num_last;
    logic [WIN_WIDTH-1:0] win_p0;
    logic [WIN_WIDTH-1:0] cap_win;
    logic                 first_beat_p0, last_beat_p0, final_beat_p0;
    logic                 vld_p1, first_p1, last_p1;
    logic                 cap_pend;
    logic                 issue, start_acc, capture, accept;

    assign start_acc = (state == ST_IDLE) && start;

    // Only beat 0 may stall: wait while an earlier result still awaits
    // capture, or while the previous window's last beat sits in D and the
    // output register is occupied (its capture could not be guaranteed).
    assign issue   = (state == ST_RUN) &&
                     !(first_beat_p0 && (cap_pend || (last_p1 && out_valid)));
    assign capture = cap_pend && (!out_valid || out_ready);
    assign accept  = out_valid && out_ready;

    dw_seq_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIN_WIDTH  (WIN_WIDTH),
        .FILTER_SIZE(FILTER_SIZE)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_acc),
        .adv       (issue),
        .last_win  (num_last),
        .win       (win_p0),
        .mem_addr  (mem_addr),
        .first_beat(first_beat_p0),
        .last_beat (last_beat_p0),
        .final_beat(final_beat_p0)
    );

    assign mem_rd = issue;

    // ---- stage A -> stage D boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            num_last  <= '0;
            vld_p1    <= 1'b0;
            first_p1  <= 1'b0;
            last_p1   <= 1'b0;
            cap_win   <= '0;
            cap_pend  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_win   <= '0;
        end else begin
            vld_p1   <= issue;
            first_p1 <= issue && first_beat_p0;
            last_p1  <= issue && last_beat_p0;
            if (issue && last_beat_p0)
                cap_win <= win_p0;

            // ---- stage D -> capture boundary ----
            if (last_p1)
                cap_pend <= 1'b1;
            else if (capture)
                cap_pend <= 1'b0;

            // A same-cycle capture keeps out_valid high over an accept.
            if (capture) begin
                out_data  <= Result;
                out_win   <= cap_win;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end

            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_windows == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_RUN;
                            busy     <= 1'b1;
                            num_last <= num_windows - WIN_WIDTH'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (issue && final_beat_p0)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Final window has left D and been captured; finish on its accept.
                    if (!cap_pend && !vld_p1 && accept) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign first_data = first_p1;
    assign Kernel     = vld_p1 ? k_rdata : '0;
    assign Input_Act  = vld_p1 ? a_rdata : '0;

`ifdef DW_SEQ_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic stall;
    assign stall = (state == ST_RUN) && !issue;

    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy)
                perf_cycles <= sat_inc(perf_cycles);
            if (stall)
                perf_stalls <= sat_inc(perf_stalls);
        end
    end
`endif

endmodule

// File: tb/tb_dw_simd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dw_simd_sequencer
// Directed bench for dw_simd_sequencer. A sync-read buffer model returns
// kernel lane = beat+1 and activation lane = beat+1+win+lane, and a simple
// SIMD model multiply-accumulates each beat, so window w lane i sums to
// 285 + 45*(w+i).
// ---------------------------------------------------------------------------
module tb_dw_simd_sequencer;

    localparam int NP = 16;
    localparam int DW = 8;
    localparam int OW = 32;
    localparam int AW = 18;
    localparam int WW = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [WW-1:0]      num_windows;
    logic               busy, done;
    logic [AW-1:0]      mem_addr;
    logic               mem_rd;
    logic [NP*DW-1:0]   k_rdata, a_rdata;
    logic               first_data;
    logic [NP*DW-1:0]   Kernel, Input_Act;
    logic [NP*OW-1:0]   Result;
    logic               out_valid, out_ready;
    logic [NP*OW-1:0]   out_data;
    logic [WW-1:0]      out_win;
`ifdef DW_SEQ_PERF_CNT_EN
    logic [31:0]        perf_cycles, perf_stalls;
`endif

    dw_simd_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_windows(num_windows),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .k_rdata    (k_rdata),
        .a_rdata    (a_rdata),
        .first_data (first_data),
        .Kernel     (Kernel),
        .Input_Act  (Input_Act),
        .Result     (Result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_win    (out_win)
`ifdef DW_SEQ_PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles),
        .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] exp_data(input int w);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < NP; i++)
            r[i*OW +: OW] = 32'(285 + 45 * (w + i));
        return r;
    endfunction

    // Sync-read buffers: data for the address of a mem_rd cycle appears next cycle.
    initial begin
        k_rdata = '0;
        a_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_rd) begin
            for (int i = 0; i < NP; i++) begin
                k_rdata[i*DW +: DW] <= 8'((int'(mem_addr) % 9) + 1);
                a_rdata[i*DW +: DW] <= 8'((int'(mem_addr) % 9) + 1 + int'(mem_addr) / 9 + i);
            end
        end
    end

    // SIMD model: first_data restarts the accumulator, other beats add on.
    logic [31:0] acc [NP];
    initial for (int i = 0; i < NP; i++) acc[i] = '0;
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (first_data)
                acc[i] <= 32'(Kernel[i*DW +: DW]) * 32'(Input_Act[i*DW +: DW]);
            else
                acc[i] <= acc[i] + 32'(Kernel[i*DW +: DW]) * 32'(Input_Act[i*DW +: DW]);
        end
    end
    always_comb begin
        Result = '0;
        for (int i = 0; i < NP; i++)
            Result[i*OW +: OW] = acc[i];
    end

    // Monitor, sampled on the falling edge.
    int n_rd, n_first, n_done, n_acc, n_first_bad, n_bubble_bad;
    int busy_cyc, obs_stall, tot_beats, exp_win;
    logic prev_rd = 1'b0;
    int   prev_addr = 0;

    task automatic mon_clear();
        n_rd = 0; n_first = 0; n_done = 0; n_acc = 0;
        n_first_bad = 0; n_bubble_bad = 0;
        busy_cyc = 0; obs_stall = 0; exp_win = 0;
    endtask

    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (busy && !mem_rd && n_rd < tot_beats) obs_stall++;
        if (mem_rd) n_rd++;
        if (first_data) n_first++;
        if (done) n_done++;
        if (first_data !== (prev_rd && (prev_addr % 9 == 0))) n_first_bad++;
        if (!prev_rd && (Kernel != '0 || Input_Act != '0 || first_data)) n_bubble_bad++;
        if (out_valid && out_ready) begin
            chk("out_win", 512'(out_win), 512'(exp_win));
            chk("out_data", out_data, exp_data(exp_win));
            exp_win++;
            n_acc++;
        end
        prev_rd   = mem_rd;
        prev_addr = int'(mem_addr);
    end

    int done_cyc;

    // Caller is 1 time unit after a rising edge; that cycle is cycle 0.
    task automatic run_seq(input int nw, input int ready_at, input int restart_at);
        bit seen;
        mon_clear();
        tot_beats   = nw * 9;
        seen        = 1'b0;
        done_cyc    = -1;
        out_ready   = (ready_at == 0);
        num_windows = WW'(nw);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 400; k++) begin
            if (k == ready_at) out_ready = 1'b1;
            if (k == restart_at) begin
                start       = 1'b1;
                num_windows = WW'(5);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen     = 1'b1;
                done_cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", 512'(seen), 512'(1));
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_first_bad"}, 512'(n_first_bad), 512'(0));
        chk({tag, "_bubble_bad"}, 512'(n_bubble_bad), 512'(0));
        chk({tag, "_done_cnt"}, 512'(n_done), 512'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        reset = 1'b1; start = 1'b0; num_windows = '0; out_ready = 1'b1;
        mon_clear(); tot_beats = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_ctl", 512'({busy, done, mem_rd, first_data, out_valid}), 512'(0));
        chk("rst_addr", 512'({out_win, mem_addr}), 512'(0));
        chk("rst_kern", 512'({Kernel, Input_Act}), 512'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: single window
        run_seq(1, 0, 0);
        chk("s1_rd", 512'(n_rd), 512'(9));
        chk("s1_first", 512'(n_first), 512'(1));
        chk("s1_acc", 512'(n_acc), 512'(1));
        chk("s1_done_cyc", 512'(done_cyc), 512'(13));
        chk("s1_busy", 512'(busy_cyc), 512'(12));
        chk_stream("s1");

        // 2: four windows at full rate
        run_seq(4, 0, 0);
        chk("s2_rd", 512'(n_rd), 512'(36));
        chk("s2_stall", 512'(obs_stall), 512'(0));
        chk("s2_first", 512'(n_first), 512'(4));
        chk("s2_acc", 512'(n_acc), 512'(4));
        chk("s2_busy", 512'(busy_cyc), 512'(39));
        chk("s2_done_cyc", 512'(done_cyc), 512'(40));
        chk_stream("s2");

        // 3: consumer back-pressure until cycle 40 stalls window 2 beat 0 (cycles 19..40)
        run_seq(3, 40, 0);
        chk("s3_rd", 512'(n_rd), 512'(27));
        chk("s3_stall", 512'(obs_stall), 512'(22));
        chk("s3_acc", 512'(n_acc), 512'(3));
        chk("s3_busy", 512'(busy_cyc), 512'(52));
        chk("s3_done_cyc", 512'(done_cyc), 512'(53));
        chk_stream("s3");
`ifdef DW_SEQ_PERF_CNT_EN
        chk("s6_perf_stalls", 512'(perf_stalls), 512'(22));
        chk("s6_perf_obs", 512'(perf_stalls), 512'(obs_stall));
        chk("s6_perf_cycles", 512'(perf_cycles), 512'(52));
`endif

        // 4: reset on beat 5 of window 2 (address 23), then a clean run
        mon_clear();
        tot_beats   = 36;
        out_ready   = 1'b1;
        num_windows = WW'(4);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (mem_rd && mem_addr == AW'(23)) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("s4_hit", 512'(hit), 512'(1));
        chk("s4_pre_acc", 512'(n_acc), 512'(2));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("s4_rst_ctl", 512'({busy, done, mem_rd, first_data, out_valid}), 512'(0));
        chk("s4_rst_addr", 512'({out_win, mem_addr}), 512'(0));
        chk("s4_rst_kern", 512'({Kernel, Input_Act}), 512'(0));
        chk("s4_rst_odata", out_data, 512'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        run_seq(2, 0, 0);
        chk("s4_rd", 512'(n_rd), 512'(18));
        chk("s4_acc", 512'(n_acc), 512'(2));
        chk("s4_done_cyc", 512'(done_cyc), 512'(22));
        chk_stream("s4");

        // 5: zero windows, then a restart attempt while busy
        run_seq(0, 0, 0);
        chk("s5_zero_done_cyc", 512'(done_cyc), 512'(1));
        chk("s5_zero_rd", 512'(n_rd), 512'(0));
        chk("s5_zero_acc", 512'(n_acc), 512'(0));
        chk("s5_zero_busy", 512'(busy_cyc), 512'(0));
        chk("s5_zero_done_cnt", 512'(n_done), 512'(1));
        run_seq(2, 0, 5);
        chk("s5_busy_rd", 512'(n_rd), 512'(18));
        chk("s5_busy_acc", 512'(n_acc), 512'(2));
        chk("s5_busy_done_cyc", 512'(done_cyc), 512'(22));
        chk_stream("s5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
